// File: rtl/data_memory_mc.sv
// Multi-cycle byte-addressable data memory with sub-word loads/stores and fault reporting.
// Optional build macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module data_memory_mc #(
  parameter int DEPTH   = 16,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_reg;
  logic [3:0]  count_reg;
  logic        we_reg;
  logic        uns_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] word_reg;

  // Contents survive reset; only the power-up image is fixed.
  logic [31:0] mem [DEPTH] = '{0: 32'd5, 1: 32'd20, 2: 32'd12, 3: 32'd25, default: 32'd0};

  logic          accept;
  logic          commit;
  logic          out_of_range;
  logic          misalign;
  logic          fault;
  logic          store_en;
  logic [AW-1:0] widx_in;
  logic [AW-1:0] widx_reg;
  logic [3:0]    be;
  logic [31:0]   lane_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   load_val;

  assign accept       = (state_reg == IDLE) && req;
  assign commit       = (state_reg == BUSY) && (count_reg == 4'd0);
  assign widx_in      = addr[AW+1:2];
  assign widx_reg     = addr_reg[AW+1:2];
  assign out_of_range = |addr_reg[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((size_reg == 2'b01) && addr_reg[0]) ||
                    (size_reg[1] && (addr_reg[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign fault    = out_of_range | misalign;
  assign store_en = commit && we_reg && !fault;

  // Per-lane byte enable and store data, with sub-word data replicated onto every lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        case (size_reg)
          2'b00: begin
            be[gi]              = (addr_reg[1:0] == 2'(gi));
            lane_data[gi*8 +: 8] = wdata_reg[7:0];
          end
          2'b01: begin
            be[gi]              = (addr_reg[1] == 1'(gi / 2));
            lane_data[gi*8 +: 8] = wdata_reg[(gi % 2)*8 +: 8];
          end
          default: begin
            be[gi]              = 1'b1;
            lane_data[gi*8 +: 8] = wdata_reg[gi*8 +: 8];
          end
        endcase
      end
    end
  endgenerate

  assign ld_byte = word_reg[{addr_reg[1:0], 3'b000} +: 8];
  assign ld_half = addr_reg[1] ? word_reg[31:16] : word_reg[15:0];

  always_comb begin
    load_val = word_reg;
    case (size_reg)
      2'b00:   load_val = {{24{~uns_reg & ld_byte[7]}}, ld_byte};
      2'b01:   load_val = {{16{~uns_reg & ld_half[15]}}, ld_half};
      default: load_val = word_reg;
    endcase
  end

  // Read is registered at acceptance; only one access is ever in flight, so it stays fresh.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int li = 0; li < 4; li++) begin
        if (be[li]) mem[widx_reg][li*8 +: 8] <= lane_data[li*8 +: 8];
      end
    end
    if (accept) word_reg <= mem[widx_in];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
      ready     <= 1'b1;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
      we_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      size_reg  <= 2'b00;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          rdata <= 32'd0;
          if (req) begin
            we_reg    <= we;
            uns_reg   <= unsigned_ld;
            size_reg  <= size;
            addr_reg  <= addr;
            wdata_reg <= wdata;
            count_reg <= CNT_INIT;
            ready     <= 1'b0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (count_reg == 4'd0) begin
            ack       <= 1'b1;
            err       <= fault;
            rdata     <= (fault || we_reg) ? 32'd0 : load_val;
            state_reg <= RESP;
          end else begin
            count_reg <= count_reg - 4'd1;
          end
        end
        RESP: begin
          ack       <= 1'b0;
          err       <= 1'b0;
          rdata     <= 32'd0;
          ready     <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          ack       <= 1'b0;
          err       <= 1'b0;
          rdata     <= 32'd0;
          ready     <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/data_memory_mc.md
DATA_MEMORY_MC -- requirements
Module: data_memory_mc

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of 32-bit words (power of 2, >=4).
REQ-002 SHALL have parameter LATENCY, default 1, meaning wait cycles per access (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  access request.
REQ-006 SHALL have port we  input  1  1=store, 0=load.
REQ-007 SHALL have port size  input  2  00=byte, 01=half, 10=word, 11=treated as word.
REQ-008 SHALL have port unsigned_ld  input  1  1=zero-extend, 0=sign-extend sub-word loads.
REQ-009 SHALL have port addr  input  32  byte address.
REQ-010 SHALL have port wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port ready  output  1  block idle, request accepted this edge if req=1.
REQ-012 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-013 SHALL have port rdata  output  32  load result, valid while ack=1.
REQ-014 SHALL have port err  output  1  access fault, valid while ack=1.

Function
REQ-015 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; ready=1 only in IDLE.
REQ-016 SHALL accept on rising edge with req=1 in IDLE, latch we/size/unsigned_ld/addr/wdata, load counter with LATENCY-1, enter BUSY.
REQ-017 SHALL ignore req outside IDLE (no queuing); latched fields do not change until next acceptance.
REQ-018 SHALL decrement counter each BUSY edge; on the edge where counter==0, commit store, register rdata/err, enter RESP.
REQ-019 SHALL hold ack=1 for exactly the one RESP cycle, then return to IDLE; ack is asserted LATENCY cycles after the acceptance edge; throughput is one access per LATENCY+2 cycles.
REQ-020 SHALL index words by addr[31:2]; addr[31:2] >= DEPTH is out-of-range: err=1, rdata=0, no store.
REQ-021 SHALL use little-endian lanes: byte lane addr[1:0], half lane addr[1].
REQ-022 SHALL write only the addressed lane on byte/half stores (wdata[7:0]/wdata[15:0]); other bytes unchanged.
REQ-023 SHALL extract loaded byte/half and zero- or sign-extend per unsigned_ld; word loads return the full word.
REQ-024 SHALL drive rdata=0 on stores and on any faulted access; rdata and err are 0 outside RESP.
REQ-025 SHALL initialise memory at time zero to all zero except words 0..3 = 5, 20, 12, 25.

Reset
REQ-026 SHALL on rst_n=0 immediately force IDLE, counter=0, ack=0, err=0, rdata=0, ready=1 once released.
REQ-027 SHALL abort an in-flight access on reset; a store not yet committed is never written.
REQ-028 SHALL NOT clear memory contents on reset.

Configuration
REQ-029 SHALL, with DMEM_MISALIGN_TRAP_EN defined, flag half with addr[0]=1 or word with addr[1:0]!=0 as err=1, rdata=0, no store.
REQ-030 SHALL, without DMEM_MISALIGN_TRAP_EN, ignore misaligning low bits (half uses addr[1], word uses addr[31:2]) and raise err only for out-of-range.

Verification
REQ-031 SHALL cover: LATENCY=1, load word addr 0x4 -> ack one cycle later in RESP, rdata=20, err=0, ready low 2 cycles.
REQ-032 SHALL cover: store byte 0xAB to addr 0x9, then load word 0x8 -> rdata=0x0000AB0C.
REQ-033 SHALL cover: word 0 = 0x000080FF; load byte addr 0x0 signed -> 0xFFFFFFFF; unsigned -> 0x000000FF; load half signed addr 0x0 -> 0xFFFF80FF.
REQ-034 SHALL cover: LATENCY=4, store addr 0x40 with DEPTH=16 -> ack after 4 cycles, err=1, memory unchanged.
REQ-035 SHALL cover: word store 0x12345678 to addr 0x6 -> with DMEM_MISALIGN_TRAP_EN err=1, word 1 unchanged; without, word 1 = 0x12345678, err=0.
REQ-036 SHALL cover: rst_n low during BUSY of a store to addr 0xC -> ack never pulses, word 3 remains 25, ready=1 after release.
